// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB down-counting timer: register offsets,
// CTRL bit positions and FSM state encoding.
package apb_timer_pkg;

  localparam logic [11:0] OFS_CTRL   = 12'h000;
  localparam logic [11:0] OFS_PRESC  = 12'h004;
  localparam logic [11:0] OFS_LOAD   = 12'h008;
  localparam logic [11:0] OFS_VALUE  = 12'h00C;
  localparam logic [11:0] OFS_STATUS = 12'h010;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_IE      = 1;
  localparam int CTRL_ONESHOT = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic logic is_mapped(input logic [11:0] ofs);
    logic hit;
    case (ofs)
      OFS_CTRL, OFS_PRESC, OFS_LOAD, OFS_VALUE, OFS_STATUS: hit = 1'b1;
      default:                                              hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/apb_timer_presc.sv
// Prescaler: produces a one-cycle tick every presc+1 cycles while running.
module apb_timer_presc #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               clr,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_r;

  assign tick = run & (cnt_r == presc);

  // clr has priority so a restart or PRESC write always begins a fresh period
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {PRESC_W{1'b0}};
    end else if (clr || tick) begin
      cnt_r <= {PRESC_W{1'b0}};
    end else if (run) begin
      cnt_r <= cnt_r + {{(PRESC_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/apb_timer.sv
// APB3 zero-wait-state timer: register file, VALUE down-counter and IDLE/RUN
// control; raises a level interrupt when the count expires.
module apb_timer
  import apb_timer_pkg::*;
#(
  parameter int WIDTH_PAD = 32,
  parameter int WIDTH_PDA = 32,
  parameter int PRESC_W   = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic                 PWRITE,
  input  logic [WIDTH_PAD-1:0] PADDR,
  input  logic [WIDTH_PDA-1:0] PWDATA,
  output logic [WIDTH_PDA-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic                 IRQ
);

  state_t               state_r, state_next;
  logic                 en_r, ie_r, oneshot_r, pend_r;
  logic [PRESC_W-1:0]   presc_r;
  logic [WIDTH_PDA-1:0] load_r, value_r, rdata_s;
  logic [11:0]          ofs_s;
  logic setup_s, err_s, wr_s, run_s, tick_s, expire_s, start_s;
  logic ctrl_wr_s, presc_wr_s, load_wr_s, status_wr_s;
  logic unused_s;

  assign unused_s    = ^PADDR[WIDTH_PAD-1:12];
  assign ofs_s       = PADDR[11:0];
  assign setup_s     = PSEL & ~PENABLE;
  assign err_s       = (PADDR[1:0] != 2'b00) | ~is_mapped(ofs_s) | (PWRITE & (ofs_s == OFS_VALUE));
  assign wr_s        = PSEL & PENABLE & PWRITE & ~err_s;
  assign ctrl_wr_s   = wr_s & (ofs_s == OFS_CTRL);
  assign presc_wr_s  = wr_s & (ofs_s == OFS_PRESC);
  assign load_wr_s   = wr_s & (ofs_s == OFS_LOAD);
  assign status_wr_s = wr_s & (ofs_s == OFS_STATUS);
  assign start_s     = ctrl_wr_s & ~run_s & PWDATA[CTRL_EN];
  assign expire_s    = tick_s & (value_r == {WIDTH_PDA{1'b0}});
  assign PREADY      = 1'b1;
  assign IRQ         = pend_r & ie_r;

  apb_timer_presc #(.PRESC_W(PRESC_W)) u_presc (
    .clk   (PCLK),
    .rst   (PRESET),
    .run   (run_s),
    .clr   (presc_wr_s | start_s),
    .presc (presc_r),
    .tick  (tick_s)
  );

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // A software EN=0 write beats a same-cycle expiry; an EN=1 write in RUN never restarts
  always_comb begin
    state_next = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_next = ST_RUN;
        else         state_next = ST_IDLE;
      end
      ST_RUN: begin
        if (ctrl_wr_s && !PWDATA[CTRL_EN])  state_next = ST_IDLE;
        else if (expire_s && oneshot_r)     state_next = ST_IDLE;
        else                                state_next = ST_RUN;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    run_s = 1'b0;
    case (state_r)
      ST_RUN:  run_s = 1'b1;
      ST_IDLE: run_s = 1'b0;
      default: run_s = 1'b0;
    endcase
  end

  always_comb begin
    rdata_s = {WIDTH_PDA{1'b0}};
    case (ofs_s)
      OFS_CTRL:   rdata_s = {{(WIDTH_PDA-3){1'b0}}, oneshot_r, ie_r, en_r};
      OFS_PRESC:  rdata_s = {{(WIDTH_PDA-PRESC_W){1'b0}}, presc_r};
      OFS_LOAD:   rdata_s = load_r;
      OFS_VALUE:  rdata_s = value_r;
      OFS_STATUS: rdata_s = {{(WIDTH_PDA-1){1'b0}}, pend_r};
      default:    rdata_s = {WIDTH_PDA{1'b0}};
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      en_r      <= 1'b0;
      ie_r      <= 1'b0;
      oneshot_r <= 1'b0;
      pend_r    <= 1'b0;
      presc_r   <= {PRESC_W{1'b0}};
      load_r    <= {WIDTH_PDA{1'b0}};
      value_r   <= {WIDTH_PDA{1'b0}};
      PRDATA    <= {WIDTH_PDA{1'b0}};
      PSLVERR   <= 1'b0;
    end else begin
      en_r <= (state_next == ST_RUN);
      if (ctrl_wr_s) begin
        ie_r      <= PWDATA[CTRL_IE];
        oneshot_r <= PWDATA[CTRL_ONESHOT];
      end
      if (presc_wr_s) presc_r <= PWDATA[PRESC_W-1:0];
      if (load_wr_s)  load_r  <= PWDATA;
      // reload samples LOAD as it stands before any same-cycle LOAD write
      if (start_s) begin
        value_r <= load_r;
      end else if (tick_s) begin
        if (!expire_s)      value_r <= value_r - {{(WIDTH_PDA-1){1'b0}}, 1'b1};
        else if (oneshot_r) value_r <= {WIDTH_PDA{1'b0}};
        else                value_r <= load_r;
      end
      if (expire_s)                         pend_r <= 1'b1;
      else if (status_wr_s && PWDATA[0])    pend_r <= 1'b0;
      if (setup_s && !PWRITE) PRDATA <= err_s ? {WIDTH_PDA{1'b0}} : rdata_s;
      PSLVERR <= setup_s & err_s;
    end
  end

endmodule

// File: tb/tb_apb_timer.sv
// Scoreboard bench for apb_timer: a behavioural timer model predicts every
// APB response and the IRQ level; a monitor compares them against the DUT.
module tb_apb_timer;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = 32'h0, PWDATA = 32'h0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, IRQ;

  int checks = 0;
  int errors = 0;

  typedef struct { bit rd; logic [31:0] data; bit err; } exp_t;
  exp_t sb[$];

  // behavioural model of the programmer-visible timer
  bit          m_run, m_ie, m_os, m_pend;
  logic [15:0] m_presc, m_cnt;
  logic [31:0] m_load, m_value;

  apb_timer dut (
    .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .IRQ(IRQ)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit bad_access(input logic [11:0] o, input bit w);
    if (o[1:0] != 2'b00) return 1'b1;
    if (!(o inside {12'h000, 12'h004, 12'h008, 12'h00C, 12'h010})) return 1'b1;
    return w && (o == 12'h00C);
  endfunction

  function automatic logic [31:0] read_model(input logic [11:0] o);
    case (o)
      12'h000: return {29'd0, m_os, m_ie, m_run};
      12'h004: return {16'd0, m_presc};
      12'h008: return m_load;
      12'h00C: return m_value;
      12'h010: return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  // model update on every rising edge from the inputs held during the cycle
  always @(posedge PCLK) begin
    logic [11:0] o;
    bit err, tick, expire, n_run, n_ie, n_os, n_pend;
    logic [15:0] n_presc, n_cnt;
    logic [31:0] n_load, n_value;
    exp_t e;
    if (PRESET) begin
      m_run = 0; m_ie = 0; m_os = 0; m_pend = 0;
      m_presc = 16'd0; m_cnt = 16'd0; m_load = 32'd0; m_value = 32'd0;
    end else begin
      o = PADDR[11:0];
      err = bad_access(o, PWRITE);
      if (PSEL && !PENABLE) begin
        e.rd = !PWRITE; e.err = err; e.data = err ? 32'd0 : read_model(o);
        sb.push_back(e);
      end
      tick   = m_run && (m_cnt == m_presc);
      expire = tick && (m_value == 0);
      n_run = m_run; n_ie = m_ie; n_os = m_os; n_pend = m_pend;
      n_presc = m_presc; n_load = m_load; n_value = m_value; n_cnt = m_cnt;
      if (m_run) n_cnt = tick ? 16'd0 : m_cnt + 16'd1;
      if (tick) begin
        if (m_value != 0) n_value = m_value - 1;
        else begin
          n_pend = 1;
          if (m_os) begin n_run = 0; n_value = 0; end
          else n_value = m_load;
        end
      end
      if (PSEL && PENABLE && PWRITE && !err) begin
        case (o)
          12'h000: begin
            n_ie = PWDATA[1]; n_os = PWDATA[2];
            if (!m_run && PWDATA[0]) begin n_run = 1; n_value = m_load; n_cnt = 0; end
            else if (m_run && !PWDATA[0]) n_run = 0;
          end
          12'h004: begin n_presc = PWDATA[15:0]; n_cnt = 0; end
          12'h008: n_load = PWDATA;
          12'h010: if (PWDATA[0] && !expire) n_pend = 0;
          default: ;
        endcase
      end
      m_run = n_run; m_ie = n_ie; m_os = n_os; m_pend = n_pend;
      m_presc = n_presc; m_load = n_load; m_value = n_value; m_cnt = n_cnt;
    end
  end

  // monitor: pops an expectation for every access phase, checks IRQ every cycle
  always @(negedge PCLK) begin
    exp_t e;
    if (PSEL && PENABLE) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        if (e.rd) chk("prdata", PRDATA, e.data);
        chk("pslverr", {31'd0, PSLVERR}, {31'd0, e.err});
        chk("pready", {31'd0, PREADY}, 32'd1);
      end
    end
    chk("irq", {31'd0, IRQ}, {31'd0, m_pend & m_ie});
  end

  task automatic apb(input bit w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] rd, output logic err);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    rd = PRDATA; err = PSLVERR;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd; logic err;
    apb(1'b1, a, d, rd, err);
  endtask

  task automatic pulse_reset();
    @(posedge PCLK); #1; PRESET = 1'b1;
    @(posedge PCLK); #1; PRESET = 1'b0;
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  logic [31:0] addrs [9] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h20, 32'h2, 32'hD};

  initial begin
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // reset state of every register
    for (int i = 0; i < 5; i++) begin
      apb(1'b0, 32'(i * 4), 32'h0, rd, err);
      chk("reset_rd", rd, 32'd0);
      chk("reset_err", {31'd0, err}, 32'd0);
    end
    chk("reset_pready", {31'd0, PREADY}, 32'd1);

    // periodic, PRESC=0, LOAD=3: IRQ on the 5th cycle after the enable write
    wr(32'h4, 32'd0); wr(32'h8, 32'd3); wr(32'h0, 32'h3);
    lat = 0;
    for (int i = 1; i <= 20 && lat == 0; i++) begin
      @(negedge PCLK);
      if (IRQ) lat = i;
    end
    chk("irq_latency", 32'(lat), 32'd5);
    wr(32'h10, 32'd1);
    wr(32'h0, 32'h0); wr(32'h10, 32'd1);

    // one-shot, PRESC=2, LOAD=1
    wr(32'h4, 32'd2); wr(32'h8, 32'd1); wr(32'h0, 32'h7);
    repeat (12) @(negedge PCLK);
    apb(1'b0, 32'h0, 32'h0, rd, err);  chk("oneshot_ctrl", rd, 32'h6);
    apb(1'b0, 32'hC, 32'h0, rd, err);  chk("oneshot_value", rd, 32'h0);
    apb(1'b0, 32'h10, 32'h0, rd, err); chk("oneshot_pend", rd, 32'h1);
    wr(32'h10, 32'd1);
    repeat (8) @(negedge PCLK);
    apb(1'b0, 32'h10, 32'h0, rd, err); chk("oneshot_no_repend", rd, 32'h0);

    // illegal accesses
    apb(1'b1, 32'hC, 32'h55, rd, err);  chk("err_wr_value", {31'd0, err}, 32'd1);
    apb(1'b0, 32'h20, 32'h0, rd, err);  chk("err_rd_unmapped", {31'd0, err}, 32'd1);
    chk("err_rd_data", rd, 32'd0);
    apb(1'b1, 32'h5, 32'h77, rd, err);  chk("err_unaligned", {31'd0, err}, 32'd1);
    apb(1'b0, 32'h8, 32'h0, rd, err);   chk("err_load_kept", rd, 32'd1);
    chk("err_load_ok", {31'd0, err}, 32'd0);

    // W1C on an expiry cycle: LOAD=0 expires on every tick
    wr(32'h4, 32'd0); wr(32'h8, 32'd0); wr(32'h0, 32'h3);
    wr(32'h10, 32'd1);
    @(negedge PCLK); chk("w1c_vs_set", {31'd0, IRQ}, 32'd1);
    wr(32'h0, 32'h0); wr(32'h10, 32'd1);

    // LOAD 5 -> 9 mid-run
    wr(32'h8, 32'd5); wr(32'h0, 32'h1); wr(32'h8, 32'd9);
    apb(1'b0, 32'hC, 32'h0, rd, err); chk("load_mid_old", {31'd0, rd <= 32'd5}, 32'd1);
    repeat (6) @(negedge PCLK);
    apb(1'b0, 32'hC, 32'h0, rd, err);
    wr(32'h0, 32'h0);

    // reset while running with IRQ asserted
    wr(32'h8, 32'd0); wr(32'h0, 32'h1); wr(32'h0, 32'h0);
    wr(32'h8, 32'h1234); wr(32'h4, 32'hFFFF); wr(32'h0, 32'h3);
    apb(1'b0, 32'hC, 32'h0, rd, err); chk("pre_rst_value", rd, 32'h1234);
    chk("pre_rst_irq", {31'd0, IRQ}, 32'd1);
    pulse_reset();
    @(negedge PCLK); chk("rst_irq", {31'd0, IRQ}, 32'd0);
    apb(1'b0, 32'h0, 32'h0, rd, err);  chk("rst_ctrl", rd, 32'd0);
    apb(1'b0, 32'hC, 32'h0, rd, err);  chk("rst_value", rd, 32'd0);
    apb(1'b0, 32'h10, 32'h0, rd, err); chk("rst_status", rd, 32'd0);

    // randomized traffic, checked against the model by the monitor
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 9))
        0: wr(32'h0, 32'($urandom_range(0, 7)));
        1: wr(32'h4, 32'($urandom_range(0, 3)));
        2: wr(32'h8, 32'($urandom_range(0, 6)));
        3: wr(32'h10, 32'($urandom_range(0, 1)));
        4, 5, 6: apb(1'b0, addrs[$urandom_range(0, 8)], $urandom, rd, err);
        7: wr(($urandom_range(0, 1) == 0) ? 32'hC : 32'h6, $urandom);
        8: repeat ($urandom_range(1, 8)) @(negedge PCLK);
        default: begin
          if ($urandom_range(0, 19) == 0) pulse_reset();
          else apb(1'b0, 32'hC, 32'h0, rd, err);
        end
      endcase
    end

    repeat (2) @(negedge PCLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
